// File: rtl/rob_multi.sv
// rob_multi: parametrised reorder buffer.
//
// Allocates entries in program order at the tail, takes results from
// WB_PORTS writeback ports, and retires completed entries in order from the
// head. Retirement produces registered register-file / store commit strobes.
// A tag-based flush squashes every entry younger than flush_tag.
//
// Optional feature macro: ROB_DUAL_COMMIT_EN
//   defined   : two retire slots per cycle (head advances by 0, 1 or 2)
//   undefined : one retire slot; commit2/commit_SW2/commit_addr2/commit_val2 tied to 0
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   issue, issue_dest,
//   issue_store, issue_jal,
//   jal_address                   allocation request and entry attributes
//   tag                           tag handed to the current issue (tail pointer)
//   write_rat                     issue accepted this cycle
//   full, count                   occupancy status
//   wb_valid, wb_tag, wb_value,
//   wb_nodata                     packed writeback ports (port p at [p*W +: W])
//   flush, flush_tag              squash entries younger than flush_tag
//   commit1/commit2               register-file write for retire slot 0/1
//   commit_SW/commit_SW2          store retire for slot 0/1
//   commit_addr*/commit_val*      retiring destination and value (held when idle)
//
// Issue handshake: an issue is accepted in the cycle where issue is high and
// write_rat is high (ROB not full at the start of the cycle, no flush). The
// accepted entry receives the tag presented on 'tag' in that same cycle.

module rob_multi #(
    parameter int DEPTH    = 32,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int WB_PORTS = 4,
    parameter int JAL_W    = 10,
    localparam int TAG_W   = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue,
    input  logic [REG_W-1:0]             issue_dest,
    input  logic                         issue_store,
    input  logic                         issue_jal,
    input  logic [JAL_W-1:0]             jal_address,
    output logic [TAG_W-1:0]             tag,
    output logic                         write_rat,
    output logic                         full,
    output logic [TAG_W:0]               count,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_value,
    input  logic [WB_PORTS-1:0]          wb_nodata,
    input  logic                         flush,
    input  logic [TAG_W-1:0]             flush_tag,
    output logic                         commit1,
    output logic                         commit2,
    output logic                         commit_SW,
    output logic                         commit_SW2,
    output logic [REG_W-1:0]             commit_addr,
    output logic [REG_W-1:0]             commit_addr2,
    output logic [DATA_W-1:0]            commit_val,
    output logic [DATA_W-1:0]            commit_val2
);

    localparam int CNT_W = TAG_W + 1;

    // Entry storage
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  ready_q, ready_d;
    logic [DEPTH-1:0]  store_q, store_d;
    logic [REG_W-1:0]  dest_q  [DEPTH];
    logic [REG_W-1:0]  dest_d  [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [DATA_W-1:0] value_d [DEPTH];

    // Pointers and occupancy
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Registered commit outputs, slot 0
    logic              commit1_q, commit1_d;
    logic              commit_sw_q, commit_sw_d;
    logic [REG_W-1:0]  commit_addr_q, commit_addr_d;
    logic [DATA_W-1:0] commit_val_q, commit_val_d;

`ifdef ROB_DUAL_COMMIT_EN
    // Registered commit outputs, slot 1
    logic              commit2_q, commit2_d;
    logic              commit_sw2_q, commit_sw2_d;
    logic [REG_W-1:0]  commit_addr2_q, commit_addr2_d;
    logic [DATA_W-1:0] commit_val2_q, commit_val2_d;
    logic [TAG_W-1:0]  head1;
`endif

    logic              full_c;
    logic              issue_ok;
    logic              ret0;
    logic              ret1;
    logic [TAG_W-1:0]  flush_n;
    logic [TAG_W-1:0]  wb_t;
    logic [TAG_W-1:0]  sq_off;

    // Retire decision and pointer bookkeeping, all from start-of-cycle state
    always_comb begin
        full_c   = (count_q == CNT_W'(DEPTH));
        issue_ok = issue & ~full_c & ~flush;
        ret0     = valid_q[head_q] & ready_q[head_q];
`ifdef ROB_DUAL_COMMIT_EN
        head1    = head_q + TAG_W'(1);
        // When the flush keeps only the head, head+1 is being squashed, so
        // it must not also retire (it would be counted twice).
        ret1     = ret0 & valid_q[head1] & ready_q[head1]
                   & ~(flush & (flush_tag == head_q));
`else
        ret1     = 1'b0;
`endif
        // Number of entries strictly younger than flush_tag; correct when
        // full too, because head == tail then and the difference wraps.
        flush_n  = flush ? (tail_q - flush_tag - TAG_W'(1)) : '0;

        head_d   = head_q + TAG_W'(ret0) + TAG_W'(ret1);
        if (flush) begin
            tail_d = flush_tag + TAG_W'(1);
        end else if (issue_ok) begin
            tail_d = tail_q + TAG_W'(1);
        end else begin
            tail_d = tail_q;
        end
        count_d  = count_q + CNT_W'(issue_ok) - CNT_W'(ret0) - CNT_W'(ret1)
                   - CNT_W'(flush_n);
    end

    // Entry array next state: writeback, retire clear, allocate, squash
    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        store_d = store_q;
        dest_d  = dest_q;
        value_d = value_q;
        wb_t    = '0;
        sq_off  = '0;

        // Ascending port order so the highest port index wins the value.
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_t = wb_tag[p*TAG_W +: TAG_W];
            if (wb_valid[p] && valid_q[wb_t]) begin
                ready_d[wb_t] = 1'b1;
                if (!wb_nodata[p]) begin
                    value_d[wb_t] = wb_value[p*DATA_W +: DATA_W];
                end
            end
        end

        if (ret0) begin
            valid_d[head_q] = 1'b0;
            ready_d[head_q] = 1'b0;
        end
`ifdef ROB_DUAL_COMMIT_EN
        if (ret1) begin
            valid_d[head1] = 1'b0;
            ready_d[head1] = 1'b0;
        end
`endif

        // Tail entry is never valid here (issue is blocked when full).
        if (issue_ok) begin
            valid_d[tail_q] = 1'b1;
            ready_d[tail_q] = issue_jal;
            store_d[tail_q] = issue_store;
            dest_d[tail_q]  = issue_jal ? '1 : issue_dest;
            value_d[tail_q] = issue_jal ? DATA_W'(jal_address) : '0;
        end

        // Squash last so writebacks to squashed tags are dropped.
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                sq_off = TAG_W'(i) - flush_tag;
                if (sq_off != '0 && sq_off <= flush_n) begin
                    valid_d[i] = 1'b0;
                    ready_d[i] = 1'b0;
                end
            end
        end
    end

    // Commit output next state; addr/val hold when nothing retires
    always_comb begin
        commit1_d     = ret0 & ~store_q[head_q];
        commit_sw_d   = ret0 & store_q[head_q];
        commit_addr_d = ret0 ? dest_q[head_q]  : commit_addr_q;
        commit_val_d  = ret0 ? value_q[head_q] : commit_val_q;
`ifdef ROB_DUAL_COMMIT_EN
        commit2_d      = ret1 & ~store_q[head1];
        commit_sw2_d   = ret1 & store_q[head1];
        commit_addr2_d = ret1 ? dest_q[head1]  : commit_addr2_q;
        commit_val2_d  = ret1 ? value_q[head1] : commit_val2_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            ready_q       <= '0;
            store_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i]  <= '0;
                value_q[i] <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            commit1_q     <= 1'b0;
            commit_sw_q   <= 1'b0;
            commit_addr_q <= '0;
            commit_val_q  <= '0;
`ifdef ROB_DUAL_COMMIT_EN
            commit2_q      <= 1'b0;
            commit_sw2_q   <= 1'b0;
            commit_addr2_q <= '0;
            commit_val2_q  <= '0;
`endif
        end else begin
            valid_q       <= valid_d;
            ready_q       <= ready_d;
            store_q       <= store_d;
            dest_q        <= dest_d;
            value_q       <= value_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            commit1_q     <= commit1_d;
            commit_sw_q   <= commit_sw_d;
            commit_addr_q <= commit_addr_d;
            commit_val_q  <= commit_val_d;
`ifdef ROB_DUAL_COMMIT_EN
            commit2_q      <= commit2_d;
            commit_sw2_q   <= commit_sw2_d;
            commit_addr2_q <= commit_addr2_d;
            commit_val2_q  <= commit_val2_d;
`endif
        end
    end

    assign tag         = tail_q;
    assign write_rat   = issue_ok;
    assign full        = full_c;
    assign count       = count_q;
    assign commit1     = commit1_q;
    assign commit_SW   = commit_sw_q;
    assign commit_addr = commit_addr_q;
    assign commit_val  = commit_val_q;
`ifdef ROB_DUAL_COMMIT_EN
    assign commit2      = commit2_q;
    assign commit_SW2   = commit_sw2_q;
    assign commit_addr2 = commit_addr2_q;
    assign commit_val2  = commit_val2_q;
`else
    assign commit2      = 1'b0;
    assign commit_SW2   = 1'b0;
    assign commit_addr2 = '0;
    assign commit_val2  = '0;
`endif

endmodule

// File: tb/tb_rob_multi.sv
// tb_rob_multi: directed and randomized bench for rob_multi.
// The reference model keeps the ROB as an ordered queue of in-flight
// entries; head/tail are derived from the head tag and the queue length.

module tb_rob_multi;

    localparam int DEPTH    = 32;
    localparam int DATA_W   = 32;
    localparam int REG_W    = 5;
    localparam int WB_PORTS = 4;
    localparam int JAL_W    = 10;
    localparam int TAG_W    = $clog2(DEPTH);
`ifdef ROB_DUAL_COMMIT_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       issue;
    logic [REG_W-1:0]           issue_dest;
    logic                       issue_store;
    logic                       issue_jal;
    logic [JAL_W-1:0]           jal_address;
    logic [TAG_W-1:0]           tag;
    logic                       write_rat;
    logic                       full;
    logic [TAG_W:0]             count;
    logic [WB_PORTS-1:0]        wb_valid;
    logic [WB_PORTS*TAG_W-1:0]  wb_tag;
    logic [WB_PORTS*DATA_W-1:0] wb_value;
    logic [WB_PORTS-1:0]        wb_nodata;
    logic                       flush;
    logic [TAG_W-1:0]           flush_tag;
    logic                       commit1, commit2, commit_SW, commit_SW2;
    logic [REG_W-1:0]           commit_addr, commit_addr2;
    logic [DATA_W-1:0]          commit_val, commit_val2;

    rob_multi #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W),
        .WB_PORTS(WB_PORTS), .JAL_W(JAL_W)
    ) dut (
        .clk(clk), .rst(rst),
        .issue(issue), .issue_dest(issue_dest), .issue_store(issue_store),
        .issue_jal(issue_jal), .jal_address(jal_address),
        .tag(tag), .write_rat(write_rat), .full(full), .count(count),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .wb_nodata(wb_nodata), .flush(flush), .flush_tag(flush_tag),
        .commit1(commit1), .commit2(commit2),
        .commit_SW(commit_SW), .commit_SW2(commit_SW2),
        .commit_addr(commit_addr), .commit_addr2(commit_addr2),
        .commit_val(commit_val), .commit_val2(commit_val2)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model
    typedef struct {
        int                tg;
        bit                rdy;
        bit                st;
        int                dst;
        logic [DATA_W-1:0] val;
    } ent_t;

    ent_t              mq[$];
    int                m_head = 0;
    bit                e_c1 = 0, e_c2 = 0, e_sw = 0, e_sw2 = 0;
    int                e_a1 = 0, e_a2 = 0;
    logic [DATA_W-1:0] e_v1 = '0, e_v2 = '0;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic clear_in();
        issue       = 1'b0;
        issue_dest  = '0;
        issue_store = 1'b0;
        issue_jal   = 1'b0;
        jal_address = '0;
        wb_valid    = '0;
        wb_tag      = '0;
        wb_value    = '0;
        wb_nodata   = '0;
        flush       = 1'b0;
        flush_tag   = '0;
    endtask

    task automatic set_wb(input int p, input int t, input logic [DATA_W-1:0] v, input bit nd);
        wb_valid[p]                 = 1'b1;
        wb_tag[p*TAG_W +: TAG_W]    = TAG_W'(t);
        wb_value[p*DATA_W +: DATA_W] = v;
        wb_nodata[p]                = nd;
    endtask

    task automatic set_issue(input int d, input bit st, input bit jal, input int ja);
        issue       = 1'b1;
        issue_dest  = REG_W'(d);
        issue_store = st;
        issue_jal   = jal;
        jal_address = JAL_W'(ja);
    endtask

    // One clock: check combinational outputs, advance the model with the
    // current inputs, then check the registered commit outputs after the edge.
    task automatic tick();
        int   size, m_tail, n, fpos;
        bit   wr;
        ent_t e;
        #1;
        size   = mq.size();
        m_tail = (m_head + size) % DEPTH;
        wr     = issue && (size != DEPTH) && !flush;
        chk("tag", tag, m_tail);
        chk("full", full, size == DEPTH);
        chk("count", count, size);
        chk("write_rat", write_rat, wr);
        if (rst) begin
            mq.delete();
            m_head = 0;
            e_c1 = 0; e_c2 = 0; e_sw = 0; e_sw2 = 0;
            e_a1 = 0; e_a2 = 0; e_v1 = '0; e_v2 = '0;
        end else begin
            n = 0;
            if (size > 0 && mq[0].rdy) n = 1;
            if (DUAL && n == 1 && size > 1 && mq[1].rdy && !(flush && mq[0].tg == int'(flush_tag))) n = 2;
            e_c1 = 0; e_sw = 0; e_c2 = 0; e_sw2 = 0;
            if (n >= 1) begin
                e_c1 = !mq[0].st; e_sw = mq[0].st; e_a1 = mq[0].dst; e_v1 = mq[0].val;
            end
            if (n == 2) begin
                e_c2 = !mq[1].st; e_sw2 = mq[1].st; e_a2 = mq[1].dst; e_v2 = mq[1].val;
            end
            fpos = size;
            if (flush) begin
                for (int i = 0; i < size; i++) if (mq[i].tg == int'(flush_tag)) fpos = i + 1;
            end
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p]) begin
                    for (int i = 0; i < fpos; i++) begin
                        if (mq[i].tg == int'(wb_tag[p*TAG_W +: TAG_W])) begin
                            mq[i].rdy = 1'b1;
                            if (!wb_nodata[p]) mq[i].val = wb_value[p*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            while (mq.size() > fpos) void'(mq.pop_back());
            repeat (n) void'(mq.pop_front());
            m_head = (m_head + n) % DEPTH;
            if (wr) begin
                e.tg  = m_tail;
                e.rdy = issue_jal;
                e.st  = issue_store;
                e.dst = issue_jal ? (2**REG_W - 1) : int'(issue_dest);
                e.val = issue_jal ? DATA_W'(jal_address) : '0;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk("commit1", commit1, e_c1);
        chk("commit_SW", commit_SW, e_sw);
        chk("commit_addr", commit_addr, e_a1);
        chk("commit_val", commit_val, e_v1);
        chk("commit2", commit2, e_c2);
        chk("commit_SW2", commit_SW2, e_sw2);
        chk("commit_addr2", commit_addr2, e_a2);
        chk("commit_val2", commit_val2, e_v2);
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Write back every not-yet-ready entry until the ROB is empty.
    task automatic drain();
        int k;
        int used;
        k = 0;
        while (mq.size() != 0 && k < 200) begin
            clear_in();
            used = 0;
            for (int i = 0; i < mq.size() && used < WB_PORTS; i++) begin
                if (!mq[i].rdy) begin
                    set_wb(used, mq[i].tg, $urandom, 1'b0);
                    used++;
                end
            end
            tick();
            k++;
        end
        clear_in();
        chk("drain_count", count, 0);
    endtask

    task automatic rand_step();
        int t;
        clear_in();
        if ($urandom_range(0, 9) < 6) begin
            set_issue(int'($urandom_range(0, 31)), $urandom_range(0, 4) == 0,
                      $urandom_range(0, 6) == 0, int'($urandom_range(0, 1023)));
        end
        for (int p = 0; p < WB_PORTS; p++) begin
            if ($urandom_range(0, 1) == 1) begin
                if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                    t = mq[$urandom_range(0, mq.size() - 1)].tg;
                else
                    t = int'($urandom_range(0, DEPTH - 1));
                set_wb(p, t, $urandom, $urandom_range(0, 3) == 0);
            end
        end
        if (mq.size() > 0 && $urandom_range(0, 29) == 0) begin
            flush     = 1'b1;
            flush_tag = TAG_W'(mq[$urandom_range(0, mq.size() - 1)].tg);
        end
        if ($urandom_range(0, 199) == 0) rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int t0;
        clear_in();
        rst = 1'b1;
        #2;

        // Reset state
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_tag", tag, 0);
        chk("rst_commit1", commit1, 0);
        chk("rst_commit_SW", commit_SW, 0);

        // Fill to DEPTH, then a rejected 33rd issue
        for (int i = 0; i < DEPTH; i++) begin
            clear_in();
            set_issue(i % 31, 1'b0, 1'b0, 0);
            tick();
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, DEPTH);
        clear_in();
        set_issue(1, 1'b0, 1'b0, 0);
        #1;
        chk("over_write_rat", write_rat, 0);
        tick();
        chk("over_tail", tag, 0);
        chk("over_count", count, DEPTH);
        do_reset();

        // Out-of-order writeback, in-order retire
        clear_in(); set_issue(3, 1'b0, 1'b0, 0); tick();
        clear_in(); set_issue(4, 1'b0, 1'b0, 0); tick();
        clear_in(); set_wb(0, 1, 32'hBB, 1'b0); tick();
        clear_in(); set_wb(2, 0, 32'hAA, 1'b0); tick();
        clear_in(); tick();
        chk("ooo_c1", commit1, 1);
        chk("ooo_addr", commit_addr, 3);
        chk("ooo_val", commit_val, 32'hAA);
        if (DUAL) begin
            chk("ooo_c2", commit2, 1);
            chk("ooo_addr2", commit_addr2, 4);
            chk("ooo_val2", commit_val2, 32'hBB);
        end else begin
            tick();
            chk("ooo_c1b", commit1, 1);
            chk("ooo_addrb", commit_addr, 4);
            chk("ooo_valb", commit_val, 32'hBB);
        end
        drain();

        // JAL is ready at allocation
        clear_in(); set_issue(9, 1'b0, 1'b1, 'h155); tick();
        clear_in(); tick();
        chk("jal_c1", commit1, 1);
        chk("jal_addr", commit_addr, 31);
        chk("jal_val", commit_val, 32'h155);

        // Store completed with wb_nodata
        t0 = (m_head + mq.size()) % DEPTH;
        clear_in(); set_issue(7, 1'b1, 1'b0, 0); tick();
        clear_in(); set_wb(3, t0, 32'hDEAD, 1'b1); tick();
        clear_in(); tick();
        chk("st_sw", commit_SW, 1);
        chk("st_c1", commit1, 0);
        chk("st_val", commit_val, 0);
        drain();

        // Flush keeps tags 0..2, writeback to squashed tag 4 dropped
        do_reset();
        for (int i = 0; i < 6; i++) begin
            clear_in(); set_issue(10 + i, 1'b0, 1'b0, 0); tick();
        end
        clear_in();
        set_issue(20, 1'b0, 1'b0, 0);
        flush = 1'b1; flush_tag = TAG_W'(2);
        set_wb(0, 4, 32'h44, 1'b0);
        set_wb(1, 1, 32'h11, 1'b0);
        #1;
        chk("flush_write_rat", write_rat, 0);
        tick();
        chk("flush_count", count, 3);
        chk("flush_tag_next", tag, 3);
        clear_in(); set_wb(0, 4, 32'h55, 1'b0); tick();
        drain();

        // Wrap-around: head at 30
        do_reset();
        for (int i = 0; i < 30; i++) begin
            clear_in(); set_issue(1, 1'b0, 1'b1, i); tick();
        end
        drain();
        clear_in(); set_issue(5, 1'b0, 1'b0, 0); tick();
        clear_in(); set_issue(6, 1'b0, 1'b0, 0); tick();
        clear_in(); set_issue(8, 1'b0, 1'b0, 0);
        set_wb(0, 30, 32'h30, 1'b0);
        set_wb(1, 31, 32'h31, 1'b0);
        tick();
        clear_in(); tick();
        chk("wrap_addr", commit_addr, 5);
        chk("wrap_val", commit_val, 32'h30);
        if (DUAL) begin
            chk("wrap_addr2", commit_addr2, 6);
            chk("wrap_val2", commit_val2, 32'h31);
        end else begin
            tick();
            chk("wrap_addrb", commit_addr, 6);
            chk("wrap_valb", commit_val, 32'h31);
        end
        chk("wrap_tail", tag, 1);
        chk("wrap_count", count, 1);
        drain();

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) rand_step();
        drain();

        // Reset dominates a simultaneous flush and issue
        for (int i = 0; i < 5; i++) begin
            clear_in(); set_issue(i, 1'b0, 1'b0, 0); tick();
        end
        clear_in();
        set_issue(2, 1'b0, 1'b0, 0);
        flush = 1'b1; flush_tag = TAG_W'(mq[1].tg);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_in();
        chk("rstflush_count", count, 0);
        chk("rstflush_tag", tag, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
